// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote per bit,
// start-glitch rejection and frame-error/break handling.
module uart_rx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_error
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rxs_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       samp_q, samp_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             v7_q, v7_d;
    logic             v8_q, v8_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_ready_q, rx_ready_d;
    logic             frame_error_q, frame_error_d;

    logic tick;
    logic vote;
    logic decide;
    logic bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_comb begin
        tick    = (div_cnt_q == DIV_LAST);
        vote    = (v7_q & v8_q) | (v7_q & rxs_q) | (v8_q & rxs_q);
        decide  = tick && (samp_q == 4'd9);
        bit_end = tick && (samp_q == 4'd15);

        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        samp_d        = samp_q;
        bit_idx_d     = bit_idx_q;
        v7_d          = v7_q;
        v8_d          = v8_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_ready_d    = 1'b0;
        frame_error_d = 1'b0;

        // Bit timing only runs while a frame is in progress
        if (state_q != S_IDLE) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            if (tick) begin
                samp_d = samp_q + 4'd1;
                if (samp_q == 4'd7) v7_d = rxs_q;
                if (samp_q == 4'd8) v8_d = rxs_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                div_cnt_d = '0;
                samp_d    = 4'd0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                if (decide && vote) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (decide) shift_d[bit_idx_q] = vote;
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            // Decide at mid-stop so a back-to-back start edge is not missed
            S_STOP: begin
                if (decide) begin
                    if (vote) begin
                        rx_data_d  = shift_q;
                        rx_ready_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            div_cnt_q     <= '0;
            samp_q        <= 4'd0;
            bit_idx_q     <= 3'd0;
            v7_q          <= 1'b0;
            v8_q          <= 1'b0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            rx_ready_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            samp_q        <= samp_d;
            bit_idx_q     <= bit_idx_d;
            v7_q          <= v7_d;
            v8_q          <= v8_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_ready_q    <= rx_ready_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_ready    = rx_ready_q;
    assign frame_error = frame_error_q;
    assign rx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial driver queues the expected byte or
// frame-error event per frame, and a monitor pops and compares on each strobe.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int      CLK_FREQ = 1600000;
    localparam int      BAUD     = 100000;
    localparam realtime BIT_NOM  = 160.0;
    localparam realtime BIT_FAST = 155.3;
    localparam realtime BIT_SLOW = 164.8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_error;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic       prev_strobe = 1'b0;
    int         checks = 0;
    int         errors = 0;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_busy     (rx_busy),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a good stop yields the byte, a low stop yields an
    // error event with rx_data still showing the last good byte.
    task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit, input realtime bit_ns);
        ev_t e;
        e.is_err = ~stop_bit;
        e.data   = stop_bit ? b : last_good;
        if (stop_bit) last_good = b;
        exp_q.push_back(e);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_bit;
        #(bit_ns);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(name, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_strobe = 1'b0;
        end else begin
            if (rx_ready || frame_error) begin
                check_output("strobe exclusive", 32'(rx_ready & frame_error), 32'd0);
                check_output("strobe one cycle", 32'(prev_strobe), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected event: got ready=%0b ferr=%0b data=%0h expected none",
                             rx_ready, frame_error, rx_data);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check_output("event kind", 32'(frame_error), 32'(e.is_err));
                    check_output("rx_data", 32'(rx_data), 32'(e.data));
                end
            end
            prev_strobe = rx_ready | frame_error;
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] digits [5];
        logic [7:0] b;
        logic       good;
        int         rate;
        realtime    bit_ns;

        digits = '{8'h32, 8'h33, 8'h31, 8'h35, 8'h37};

        idle(3);
        check_output("reset rx_data", 32'(rx_data), 32'h00);
        check_output("reset rx_ready", 32'(rx_ready), 32'd0);
        check_output("reset rx_busy", 32'(rx_busy), 32'd0);
        check_output("reset frame_error", 32'(frame_error), 32'd0);
        rst_n = 1'b1;
        idle(5);

        apply_stimulus(8'h33, 1'b1, BIT_NOM);
        idle(4);
        drain("single byte", 50);
        check_output("busy after byte", 32'(rx_busy), 32'd0);

        for (int i = 0; i < 5; i++) apply_stimulus(digits[i], 1'b1, BIT_NOM);
        idle(4);
        drain("back-to-back", 50);
        check_output("busy after burst", 32'(rx_busy), 32'd0);

        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(16);
        check_output("busy after glitch", 32'(rx_busy), 32'd0);
        drain("glitch", 1);

        apply_stimulus(8'hA5, 1'b0, BIT_NOM);
        idle(40);
        check_output("busy in break", 32'(rx_busy), 32'd1);
        drain("frame error", 1);
        rx = 1'b1;
        idle(6);
        check_output("busy after break", 32'(rx_busy), 32'd0);
        apply_stimulus(8'h41, 1'b1, BIT_NOM);
        idle(4);
        drain("after break", 50);

        // Abort a frame by reset in the middle of data bit 4
        b  = 8'h6C;
        rx = 1'b0;
        #(BIT_NOM);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            #(BIT_NOM);
        end
        rx = b[4];
        #(BIT_NOM / 2);
        rst_n = 1'b0;
        #1;
        check_output("mid-reset rx_data", 32'(rx_data), 32'h00);
        check_output("mid-reset rx_ready", 32'(rx_ready), 32'd0);
        check_output("mid-reset rx_busy", 32'(rx_busy), 32'd0);
        check_output("mid-reset frame_error", 32'(frame_error), 32'd0);
        last_good = 8'h00;
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(5);
        apply_stimulus(8'h39, 1'b1, BIT_NOM);
        idle(4);
        drain("after reset", 50);

        apply_stimulus(8'h5A, 1'b1, BIT_FAST);
        idle(6);
        drain("fast baud", 50);
        apply_stimulus(8'h5A, 1'b1, BIT_SLOW);
        idle(6);
        drain("slow baud", 50);

        for (int k = 0; k < 24; k++) begin
            b      = 8'($urandom);
            good   = ($urandom_range(0, 5) != 0);
            rate   = $urandom_range(0, 2);
            bit_ns = (rate == 0) ? BIT_FAST : ((rate == 1) ? BIT_NOM : BIT_SLOW);
            apply_stimulus(b, good, bit_ns);
            if (!good) begin
                idle($urandom_range(0, 30));
                rx = 1'b1;
                idle($urandom_range(2, 8));
            end else begin
                idle($urandom_range(0, 12));
            end
        end
        idle(4);
        drain("random", 400);
        check_output("busy at end", 32'(rx_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
